// File: rtl/adder_tree_acc_if.sv
// Handshake bundle for adder_tree_acc: input beat channel plus result channel.
interface adder_tree_acc_if #(
  parameter int NUM      = 4,
  parameter int BITS     = 16,
  parameter int OUT_BITS = 26,
  parameter int CNT_BITS = 9
);
  logic                 valid;
  logic                 ready;
  logic [NUM*BITS-1:0]  data_in;
  logic                 last;
  logic                 acc_mode;
  logic [OUT_BITS-1:0]  o;
  logic                 valid_out;
  logic                 ready_out;
  logic [CNT_BITS-1:0]  beats;
  logic                 ovf;

  // Producer of beats / consumer of results
  modport master (
    output valid, data_in, last, acc_mode, ready_out,
    input  ready, o, valid_out, beats, ovf
  );

  // The adder tree itself
  modport slave (
    input  valid, data_in, last, acc_mode, ready_out,
    output ready, o, valid_out, beats, ovf
  );
endinterface

// File: rtl/adder_tree_acc.sv
// Pipelined NUM-lane adder tree with optional per-frame accumulation.
// One input register, one register per tree level, one accumulator/output
// register. A single enable (output slot free or being drained) advances
// every stage at once, so backpressure freezes the whole pipe losslessly.
module adder_tree_acc #(
  parameter int NUM       = 4,
  parameter int BITS      = 16,
  parameter int SIGNED    = 0,
  parameter int ACC_EXTRA = 8,
  parameter int MAX_BEATS = 256
) (
  input  logic            clk,
  input  logic            resetn,
  adder_tree_acc_if.slave bus
);
  localparam int LEVELS   = $clog2(NUM);
  localparam int TW       = BITS + LEVELS;
  localparam int OUT_BITS = TW + ACC_EXTRA;
  localparam int CNT_BITS = $clog2(MAX_BEATS) + 1;
  localparam int NPAD     = 1 << LEVELS;
  localparam bit SGN      = (SIGNED != 0);

  typedef enum logic {IDLE, ACC} state_t;

  logic en;
  logic vout_q;

  assign en        = !vout_q || bus.ready_out;
  assign bus.ready = en;

  // Missing lanes of a non-power-of-two tree read as zero.
  logic [NPAD*BITS-1:0] lanes_pad;
  assign lanes_pad = (NPAD*BITS)'(bus.data_in);

  // Level 0 is the input register; level l holds NPAD>>l nodes of BITS+l bits.
  for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
    localparam int W = BITS + l;
    localparam int N = NPAD >> l;
    logic [W-1:0] node [N];
    logic         v;
    logic         lst;
    logic         md;

    if (l == 0) begin : g_in
      // Capture the (padded) input lanes of an accepted slot.
      // NOTE: datapath registers have no reset; only the valid/control bits
      // need a defined value, and v gates everything downstream.
      always_ff @(posedge clk) begin
        if (en) begin
          for (int i = 0; i < N; i++) node[i] <= lanes_pad[i*BITS +: BITS];
        end
      end

      // Input-side valid and frame control.
      // NOTE: non-blocking assignments so every stage samples pre-edge values.
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          v   <= 1'b0;
          lst <= 1'b0;
          md  <= 1'b0;
        end else if (en) begin
          v   <= bus.valid;
          lst <= bus.last;
          md  <= bus.acc_mode;
        end
      end
    end else begin : g_add
      // Pairwise add with one bit of growth; sign or zero extension by mode.
      always_ff @(posedge clk) begin
        if (en) begin
          for (int i = 0; i < N; i++) begin
            node[i] <= {SGN & g_lvl[l-1].node[2*i][W-2],   g_lvl[l-1].node[2*i]}
                     + {SGN & g_lvl[l-1].node[2*i+1][W-2], g_lvl[l-1].node[2*i+1]};
          end
        end
      end

      // Valid/control travel alongside the partial sums.
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          v   <= 1'b0;
          lst <= 1'b0;
          md  <= 1'b0;
        end else if (en) begin
          v   <= g_lvl[l-1].v;
          lst <= g_lvl[l-1].lst;
          md  <= g_lvl[l-1].md;
        end
      end
    end
  end

  logic [TW-1:0] tree_sum;
  logic          tree_v;
  logic          tree_last;
  logic          tree_mode;

  assign tree_sum  = g_lvl[LEVELS].node[0];
  assign tree_v    = g_lvl[LEVELS].v;
  assign tree_last = g_lvl[LEVELS].lst;
  assign tree_mode = g_lvl[LEVELS].md;

  // Widen the tree result; the extra top bit carries the sign only when signed.
  logic signed [TW:0]   tree_sx;
  logic [OUT_BITS-1:0]  tree_ext;
  assign tree_sx  = {SGN & tree_sum[TW-1], tree_sum};
  assign tree_ext = OUT_BITS'(tree_sx);

  state_t              state_q, state_d;
  logic [OUT_BITS-1:0] acc_q, acc_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic                sticky_q, sticky_d;
  logic [OUT_BITS-1:0] o_q, o_d;
  logic [CNT_BITS-1:0] beats_q, beats_d;
  logic                ovf_q, ovf_d;
  logic                vout_d;

  // Accumulator add with carry-out (unsigned) or sign overflow (signed).
  logic [OUT_BITS:0]   acc_wide;
  logic [OUT_BITS-1:0] acc_sum;
  logic [CNT_BITS-1:0] cnt_inc;
  logic                add_ovf;

  assign acc_wide = {1'b0, acc_q} + {1'b0, tree_ext};
  assign acc_sum  = acc_wide[OUT_BITS-1:0];
  assign cnt_inc  = cnt_q + CNT_BITS'(1);
  assign add_ovf  = SGN ? ((acc_q[OUT_BITS-1] == tree_ext[OUT_BITS-1]) &&
                           (acc_sum[OUT_BITS-1] != acc_q[OUT_BITS-1]))
                        : acc_wide[OUT_BITS];

  // Frame FSM next-state and output-register loads.
  always_comb begin
    // NOTE: every target gets a hold default first so no path infers a latch.
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    o_d      = o_q;
    beats_d  = beats_q;
    ovf_d    = ovf_q;
    vout_d   = vout_q;
    if (en) begin
      vout_d = 1'b0;
      if (tree_v) begin
        unique case (state_q)
          IDLE: begin
            if (!tree_mode) begin
              o_d     = tree_ext;
              beats_d = CNT_BITS'(1);
              ovf_d   = 1'b0;
              vout_d  = 1'b1;
            end else begin
              acc_d    = tree_ext;
              cnt_d    = CNT_BITS'(1);
              sticky_d = 1'b0;
              if (tree_last || MAX_BEATS == 1) begin
                o_d     = tree_ext;
                beats_d = CNT_BITS'(1);
                ovf_d   = 1'b0;
                vout_d  = 1'b1;
              end else begin
                state_d = ACC;
              end
            end
          end
          ACC: begin
            acc_d    = acc_sum;
            cnt_d    = cnt_inc;
            sticky_d = sticky_q | add_ovf;
            if (tree_last || cnt_inc == CNT_BITS'(MAX_BEATS)) begin
              o_d     = acc_sum;
              beats_d = cnt_inc;
              ovf_d   = sticky_q | add_ovf;
              vout_d  = 1'b1;
              state_d = IDLE;
            end
          end
        endcase
      end
    end
  end

  // Frame state, accumulator and output registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
      o_q      <= '0;
      beats_q  <= '0;
      ovf_q    <= 1'b0;
      vout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
      o_q      <= o_d;
      beats_q  <= beats_d;
      ovf_q    <= ovf_d;
      vout_q   <= vout_d;
    end
  end

  assign bus.o         = o_q;
  assign bus.beats     = beats_q;
  assign bus.ovf       = ovf_q;
  assign bus.valid_out = vout_q;
endmodule

// File: tb/tb_adder_tree_acc.sv
// Scoreboard bench for adder_tree_acc. Three instances cover the default
// configuration (a), MAX_BEATS=4 / ACC_EXTRA=0 unsigned (b) and
// SIGNED=1 / ACC_EXTRA=0 (c); sel routes stimulus to one of them.
module tb_adder_tree_acc;
  localparam int OB_A = 26, OB_B = 18, OB_C = 18;
  localparam int CB_A = 9,  CB_B = 3,  CB_C = 9;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  int          sel = 0;
  logic        s_valid = 1'b0;
  logic [63:0] s_data = '0;
  logic        s_last = 1'b0;
  logic        s_mode = 1'b0;
  logic        s_rdy_out = 1'b1;

  adder_tree_acc_if #(.NUM(4), .BITS(16), .OUT_BITS(OB_A), .CNT_BITS(CB_A)) bus_a ();
  adder_tree_acc_if #(.NUM(4), .BITS(16), .OUT_BITS(OB_B), .CNT_BITS(CB_B)) bus_b ();
  adder_tree_acc_if #(.NUM(4), .BITS(16), .OUT_BITS(OB_C), .CNT_BITS(CB_C)) bus_c ();

  adder_tree_acc #(.NUM(4), .BITS(16), .SIGNED(0), .ACC_EXTRA(8), .MAX_BEATS(256))
    dut_a (.clk(clk), .resetn(resetn), .bus(bus_a));
  adder_tree_acc #(.NUM(4), .BITS(16), .SIGNED(0), .ACC_EXTRA(0), .MAX_BEATS(4))
    dut_b (.clk(clk), .resetn(resetn), .bus(bus_b));
  adder_tree_acc #(.NUM(4), .BITS(16), .SIGNED(1), .ACC_EXTRA(0), .MAX_BEATS(256))
    dut_c (.clk(clk), .resetn(resetn), .bus(bus_c));

  assign bus_a.valid     = s_valid && (sel == 0);
  assign bus_b.valid     = s_valid && (sel == 1);
  assign bus_c.valid     = s_valid && (sel == 2);
  assign bus_a.data_in   = s_data;
  assign bus_b.data_in   = s_data;
  assign bus_c.data_in   = s_data;
  assign bus_a.last      = s_last;
  assign bus_b.last      = s_last;
  assign bus_c.last      = s_last;
  assign bus_a.acc_mode  = s_mode;
  assign bus_b.acc_mode  = s_mode;
  assign bus_c.acc_mode  = s_mode;
  assign bus_a.ready_out = (sel == 0) ? s_rdy_out : 1'b1;
  assign bus_b.ready_out = (sel == 1) ? s_rdy_out : 1'b1;
  assign bus_c.ready_out = (sel == 2) ? s_rdy_out : 1'b1;

  logic [31:0] m_o;
  logic [15:0] m_beats;
  logic        m_vout, m_ovf, m_ready;

  always_comb begin
    m_o = '0; m_beats = '0; m_vout = 1'b0; m_ovf = 1'b0; m_ready = 1'b0;
    case (sel)
      0: begin m_o = 32'(bus_a.o); m_beats = 16'(bus_a.beats); m_vout = bus_a.valid_out;
               m_ovf = bus_a.ovf; m_ready = bus_a.ready; end
      1: begin m_o = 32'(bus_b.o); m_beats = 16'(bus_b.beats); m_vout = bus_b.valid_out;
               m_ovf = bus_b.ovf; m_ready = bus_b.ready; end
      default: begin m_o = 32'(bus_c.o); m_beats = 16'(bus_c.beats); m_vout = bus_c.valid_out;
               m_ovf = bus_c.ovf; m_ready = bus_c.ready; end
    endcase
  end

  int n_vec = 0;
  int n_mis = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    longint o;
    longint beats;
    longint ovf;
  } exp_t;

  exp_t   q[$];
  bit     md_inframe = 1'b0;
  longint md_acc = 0;
  longint md_cnt = 0;
  bit     md_ovf = 1'b0;

  function automatic int cfg_ob(int s);  return (s == 0) ? OB_A : OB_B; endfunction
  function automatic bit cfg_sg(int s);  return (s == 2);               endfunction
  function automatic int cfg_mb(int s);  return (s == 1) ? 4 : 256;     endfunction

  function automatic longint lane_sum(logic [63:0] d, bit sg);
    longint s = 0;
    for (int i = 0; i < 4; i++) begin
      logic signed [15:0] xs;
      logic [15:0]        xu;
      xu = d[i*16 +: 16];
      xs = xu;
      if (sg) s += longint'(xs);
      else    s += longint'(xu);
    end
    return s;
  endfunction

  // Reduce a mathematical sum into the representable range, flagging overflow.
  function automatic longint wrap_val(longint v, int ob, bit sg, output bit ov);
    longint m    = longint'(1) << ob;
    longint half = m >> 1;
    if (sg) begin
      ov = (v >= half) || (v < -half);
      return (((v + half) % m + m) % m) - half;
    end
    ov = (v >= m) || (v < 0);
    return ((v % m) + m) % m;
  endfunction

  task automatic push_exp(input longint v, input longint n, input bit f);
    exp_t e;
    e.o     = v & ((longint'(1) << cfg_ob(sel)) - 1);
    e.beats = n;
    e.ovf   = longint'(f);
    q.push_back(e);
  endtask

  task automatic model_beat(input logic [63:0] d, input bit lst, input bit md);
    longint s;
    bit     ov;
    s = lane_sum(d, cfg_sg(sel));
    if (!md_inframe) begin
      if (!md) push_exp(s, 1, 1'b0);
      else begin
        md_acc = s; md_cnt = 1; md_ovf = 1'b0;
        if (lst || cfg_mb(sel) == 1) push_exp(s, 1, 1'b0);
        else md_inframe = 1'b1;
      end
    end else begin
      md_acc = wrap_val(md_acc + s, cfg_ob(sel), cfg_sg(sel), ov);
      md_ovf = md_ovf | ov;
      md_cnt++;
      if (lst || md_cnt == cfg_mb(sel)) begin
        push_exp(md_acc, md_cnt, md_ovf);
        md_inframe = 1'b0;
      end
    end
  endtask

  // Observe accepts and results half a cycle away from the active edge.
  always @(negedge clk) begin
    if (resetn) begin
      if (s_valid && m_ready) model_beat(s_data, s_last, s_mode);
      if (m_vout) begin
        if (q.size() == 0) check("spurious_valid_out", m_vout, 0);
        else begin
          check("o", m_o, q[0].o);
          check("beats", m_beats, q[0].beats);
          check("ovf", m_ovf, q[0].ovf);
          if (s_rdy_out) void'(q.pop_front());
          else check("ready_while_stalled", m_ready, 0);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [63:0] lanes(int a, int b, int c, int d);
    return {16'(d), 16'(c), 16'(b), 16'(a)};
  endfunction

  // Entered and left at a posedge; the beat is accepted at the final edge.
  task automatic send(input logic [63:0] d, input bit lst, input bit md);
    int n = 0;
    #1;
    s_valid = 1'b1; s_data = d; s_last = lst; s_mode = md;
    @(negedge clk);
    while (!m_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("accept_in_time", longint'(n < 200), 1);
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    #1;
    s_valid = 1'b0; s_last = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    check("drain_queue_empty", q.size(), 0);
    repeat (4) @(posedge clk);
  endtask

  bit done;

  initial begin
    int run, rises;
    bit prev;

    // Reset state, all three instances
    repeat (3) @(posedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      check("rst_valid_out", m_vout, 0);
      check("rst_o", m_o, 0);
      check("rst_beats", m_beats, 0);
      check("rst_ovf", m_ovf, 0);
    end
    sel = 0;
    @(posedge clk);
    #1 resetn = 1'b1;
    @(posedge clk);

    // 1: pass latency, then four back-to-back beats
    send(lanes(1, 2, 3, 4), 1'b0, 1'b0);
    #1 s_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 check("latency_not_early", m_vout, 0);
    @(posedge clk);
    #1 check("latency_on_time", m_vout, 1);
    @(posedge clk);
    for (int i = 0; i < 4; i++) send(lanes(i, 10, 100, 1000), 1'b0, 1'b0);
    #1 s_valid = 1'b0;
    run = 0; rises = 0; prev = 1'b0;
    repeat (8) begin
      @(negedge clk);
      run += int'(m_vout);
      if (m_vout && !prev) rises++;
      prev = m_vout;
    end
    check("b2b_output_cycles", run, 4);
    check("b2b_single_burst", rises, 1);
    @(posedge clk);
    drain();

    // 2: three-beat accumulation closed by last
    for (int i = 0; i < 3; i++) send(lanes(4, 3, 2, 1), i == 2, 1'b1);
    idle(2);
    drain();

    // 3: backpressure mid-stream
    fork
      begin
        for (int i = 0; i < 8; i++) send(lanes(i + 1, 2 * i, 7, 300 * i), 1'b0, 1'b0);
        idle(1);
      end
      begin
        repeat (3) @(posedge clk);
        #1 s_rdy_out = 1'b0;
        repeat (5) @(posedge clk);
        #1 s_rdy_out = 1'b1;
      end
    join
    drain();

    // 4 and 5 (unsigned): MAX_BEATS=4, ACC_EXTRA=0
    sel = 1;
    for (int i = 0; i < 6; i++) send(lanes(1, 0, 0, 0), i == 5, 1'b1);
    idle(2);
    drain();
    for (int i = 0; i < 2; i++) send(lanes(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF), i == 1, 1'b1);
    idle(2);
    drain();

    // 5 (signed): pass of all-ones, positive overflow, negative sum without overflow
    sel = 2;
    send(lanes(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF), 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) send(lanes(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF), i == 1, 1'b1);
    for (int i = 0; i < 3; i++) send(lanes(16'h8000, 16'h0001, 16'hFFF0, 16'h0100), i == 2, 1'b1);
    idle(2);
    drain();

    // 6: reset in the middle of a frame discards it
    sel = 0;
    send(lanes(4, 3, 2, 1), 1'b0, 1'b1);
    send(lanes(4, 3, 2, 1), 1'b0, 1'b1);
    #1;
    s_valid = 1'b0;
    resetn = 1'b0;
    q.delete();
    md_inframe = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mid_reset_valid_out", m_vout, 0);
    check("mid_reset_o", m_o, 0);
    resetn = 1'b1;
    @(posedge clk);
    send(lanes(1, 1, 1, 1), 1'b1, 1'b1);
    idle(2);
    drain();

    // Random beats, modes and lasts under random backpressure
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++)
          send({$urandom, $urandom}, $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)));
        send({$urandom, $urandom}, 1'b1, 1'b1);
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 s_rdy_out = ($urandom_range(0, 3) != 0);
        end
      end
    join
    s_rdy_out = 1'b1;
    idle(2);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
